shared_capture_arbiter: RTL and testbench

//   Round-robin arbiter that shares one capture register between NUM_REQ requesters.

---
 rtl/arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 41 ++++
 rtl/shared_capture_arbiter.sv | 94 +++++++++
 tb/tb_shared_capture_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin capture arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  // Index width that stays at least one bit wide for degenerate counts.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, scanning circularly.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [N-1:0]   mask;
  logic [2*N-1:0] dbl;
  int             sel;
  int             sel_mod;

  // Lower half holds only requests at or above ptr; upper half holds all of them,
  // so the lowest set bit of the doubled vector is the circular winner.
  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (i >= int'(ptr));
    end
    dbl = {req, req & mask};

    sel = 0;
    for (int i = 2 * N - 1; i >= 0; i--) begin
      if (dbl[i]) sel = i;
    end
    sel_mod = (sel >= N) ? sel - N : sel;

    any    = |req;
    idx    = IW'(sel_mod);
    onehot = any ? (N'(1) << sel_mod) : '0;
  end

endmodule

// File: rtl/shared_capture_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ requesters into one capture register with valid/ready.
module shared_capture_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [DATA_W-1:0]           q,
  output logic [idx_w(NUM_REQ)-1:0]   q_src,
  output logic                        q_valid,
  input  logic                        q_ready,
  output logic                        busy
);

  localparam int             IW   = idx_w(NUM_REQ);
  localparam logic [IW-1:0]  LAST = IW'(NUM_REQ - 1);

  arb_state_e           state, next_state;
  logic [IW-1:0]        ptr;
  logic [NUM_REQ-1:0]   pick_onehot;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;
  logic                 capture;
  logic                 release_q;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    capture    = 1'b0;
    release_q  = 1'b0;
    gnt        = '0;
    case (state)
      IDLE: begin
        // Grant is masked during reset so nothing looks granted while rstn is low.
        if (rstn) gnt = pick_onehot;
        if (pick_any) begin
          capture    = 1'b1;
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (q_ready) begin
          release_q  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q       <= '0;
      q_src   <= '0;
      q_valid <= 1'b0;
      ptr     <= '0;
    end else begin
      if (capture) begin
        q       <= req_data[int'(pick_idx) * DATA_W +: DATA_W];
        q_src   <= pick_idx;
        q_valid <= 1'b1;
      end
      if (release_q) begin
        q_valid <= 1'b0;
        // Explicit wrap: NUM_REQ need not be a power of two.
        ptr     <= (q_src == LAST) ? '0 : q_src + 1'b1;
      end
    end
  end

  assign busy = (state == HOLD);

endmodule

// File: tb/tb_shared_capture_arbiter.sv
// Directed bench for shared_capture_arbiter: vector table plus multi-cycle corner sequences.
module tb_shared_capture_arbiter;

  logic        clk = 1'b0;
  logic        rstn;

  logic [3:0]  req4;
  logic [31:0] data4;
  logic [3:0]  gnt4;
  logic [7:0]  q4;
  logic [1:0]  src4;
  logic        qv4, rdy4, busy4;

  logic [2:0]  req3;
  logic [23:0] data3;
  logic [2:0]  gnt3;
  logic [7:0]  q3;
  logic [1:0]  src3;
  logic        qv3, rdy3, busy3;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  shared_capture_arbiter #(.NUM_REQ(4), .DATA_W(8)) dut4 (
    .clk      (clk),
    .rstn     (rstn),
    .req      (req4),
    .req_data (data4),
    .gnt      (gnt4),
    .q        (q4),
    .q_src    (src4),
    .q_valid  (qv4),
    .q_ready  (rdy4),
    .busy     (busy4)
  );

  shared_capture_arbiter #(.NUM_REQ(3), .DATA_W(8)) dut3 (
    .clk      (clk),
    .rstn     (rstn),
    .req      (req3),
    .req_data (data3),
    .gnt      (gnt3),
    .q        (q3),
    .q_src    (src3),
    .q_valid  (qv3),
    .q_ready  (rdy3),
    .busy     (busy3)
  );

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic [3:0] gnt;
    logic       busy;
    logic       qv;
    logic [7:0] q;
    logic [1:0] src;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    logic [7:0] d4[4];
    logic [7:0] d3[3];
    d4 = '{8'hA0, 8'hB1, 8'h3C, 8'hD3};
    d3 = '{8'h3A, 8'h4B, 8'h5C};

    // Stimulus/expectation table for the 4-requester build; each row is checked before its edge.
    vecs[0]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0};
    vecs[1]  = '{4'b0100, 1'b1, 4'b0100, 1'b0, 1'b0, 8'h00, 2'd0};
    vecs[2]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 8'h3C, 2'd2};
    vecs[3]  = '{4'b0011, 1'b1, 4'b0001, 1'b0, 1'b0, 8'h3C, 2'd2};
    vecs[4]  = '{4'b0010, 1'b1, 4'b0000, 1'b1, 1'b1, 8'hA0, 2'd0};
    vecs[5]  = '{4'b0011, 1'b1, 4'b0010, 1'b0, 1'b0, 8'hA0, 2'd0};
    vecs[6]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1, 8'hB1, 2'd1};
    vecs[7]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1, 8'hB1, 2'd1};
    vecs[8]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1, 8'hB1, 2'd1};
    vecs[9]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1, 8'hB1, 2'd1};
    vecs[10] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1, 8'hB1, 2'd1};
    vecs[11] = '{4'b1111, 1'b1, 4'b0000, 1'b1, 1'b1, 8'hB1, 2'd1};
    vecs[12] = '{4'b1111, 1'b1, 4'b0100, 1'b0, 1'b0, 8'hB1, 2'd1};
    vecs[13] = '{4'b1111, 1'b1, 4'b0000, 1'b1, 1'b1, 8'h3C, 2'd2};
    vecs[14] = '{4'b1111, 1'b1, 4'b1000, 1'b0, 1'b0, 8'h3C, 2'd2};
    vecs[15] = '{4'b1111, 1'b1, 4'b0000, 1'b1, 1'b1, 8'hD3, 2'd3};
    vecs[16] = '{4'b1111, 1'b1, 4'b0001, 1'b0, 1'b0, 8'hD3, 2'd3};
    vecs[17] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 8'hA0, 2'd0};
    vecs[18] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 8'hA0, 2'd0};
    vecs[19] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'hA0, 2'd0};

    data4 = {d4[3], d4[2], d4[1], d4[0]};
    data3 = {d3[2], d3[1], d3[0]};
    req3  = '0;
    rdy3  = 1'b0;
    rdy4  = 1'b0;

    // Reset state, with requests asserted to show gnt stays low during reset.
    rstn = 1'b0;
    req4 = 4'b1111;
    #2;
    check("rst gnt", 32'(gnt4), 32'h0);
    check("rst q_valid", 32'(qv4), 32'h0);
    check("rst busy", 32'(busy4), 32'h0);
    check("rst q", 32'(q4), 32'h0);
    req4 = '0;
    do_reset();

    for (int i = 0; i < 20; i++) begin
      req4 = vecs[i].req;
      rdy4 = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d gnt", i),     32'(gnt4),  32'(vecs[i].gnt));
      check($sformatf("vec%0d busy", i),    32'(busy4), 32'(vecs[i].busy));
      check($sformatf("vec%0d q_valid", i), 32'(qv4),   32'(vecs[i].qv));
      check($sformatf("vec%0d q", i),       32'(q4),    32'(vecs[i].q));
      check($sformatf("vec%0d q_src", i),   32'(src4),  32'(vecs[i].src));
      step();
    end

    // All requesting from reset: grant order 0,1,2,3,0,... one grant every two cycles.
    req4 = '0;
    rdy4 = 1'b0;
    do_reset();
    req4 = 4'b1111;
    rdy4 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("all%0d gnt", k), 32'(gnt4), 32'(4'b0001 << (k % 4)));
      step();
      check($sformatf("all%0d idle gnt", k), 32'(gnt4), 32'h0);
      check($sformatf("all%0d q_src", k), 32'(src4), 32'(k % 4));
      check($sformatf("all%0d q", k), 32'(q4), 32'(d4[k % 4]));
      step();
    end

    // Asynchronous reset while holding 8'hA5: everything clears without a clock edge.
    req4 = '0;
    rdy4 = 1'b0;
    data4 = {d4[3], d4[2], d4[1], 8'hA5};
    do_reset();
    req4 = 4'b0001;
    step();
    check("hold q", 32'(q4), 32'hA5);
    check("hold q_valid", 32'(qv4), 32'h1);
    req4 = 4'b1111;
    #1;
    rstn = 1'b0;
    #1;
    check("async q_valid", 32'(qv4), 32'h0);
    check("async q", 32'(q4), 32'h0);
    check("async busy", 32'(busy4), 32'h0);
    check("async gnt", 32'(gnt4), 32'h0);
    check("async q_src", 32'(src4), 32'h0);
    req4 = '0;
    data4 = {d4[3], d4[2], d4[1], d4[0]};
    do_reset();

    // Three-requester build: order 0,1,2,0,... with explicit pointer wrap.
    req3 = 3'b111;
    rdy3 = 1'b1;
    for (int k = 0; k < 7; k++) begin
      #1;
      check($sformatf("n3_%0d gnt", k), 32'(gnt3), 32'(3'b001 << (k % 3)));
      step();
      check($sformatf("n3_%0d q_src", k), 32'(src3), 32'(k % 3));
      check($sformatf("n3_%0d q", k), 32'(q3), 32'(d3[k % 3]));
      check($sformatf("n3_%0d q_valid", k), 32'(qv3), 32'h1);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
